// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: shared opcodes, ALU/jump codes and the decoded bundle type for the RV32I decode stage.
package rv_decode_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_REG_AW = 5;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [9:0] ALU_ADD   = 10'h000;
  localparam logic [9:0] ALU_SUB   = 10'h100;
  localparam logic [9:0] ALU_LUI   = 10'h3F8;
  localparam logic [9:0] ALU_AUIPC = 10'h3F9;
  localparam logic [2:0] JAL_BITS  = 3'b010;
  localparam logic [2:0] JALR_BITS = 3'b011;
  typedef struct packed {
    logic [9:0]              alu_ctrl;
    logic [DEF_XLEN-1:0]     imm;
    logic                    imm_en;
    logic [DEF_REG_AW:0]     sel_a;
    logic [DEF_REG_AW-1:0]   sel_b;
    logic [DEF_REG_AW-1:0]   sel_out;
    logic [2:0]              jmp_type;
    logic                    new_jmp;
    logic [DEF_REG_AW+3:0]   lam_ctrl;
    logic                    lam_new;
    logic                    demux_alu;
    logic                    illegal;
  } bundle_t;
endpackage

// File: rtl/rv_load_scoreboard.sv
// rv_load_scoreboard: one busy bit per register for loads in flight; set wins over a same-cycle clear, x0 never busy.
module rv_load_scoreboard #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_i,
  input  logic [REG_AW-1:0] set_rd_i,
  input  logic              clr_i,
  input  logic [REG_AW-1:0] clr_rd_i,
  input  logic [REG_AW-1:0] rd_a_i,
  input  logic [REG_AW-1:0] rd_b_i,
  output logic              busy_a_o,
  output logic              busy_b_o
);
  localparam int N = 1 << REG_AW;
  logic [N-1:0] busy_q, busy_d;
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_rd_i] = 1'b0;
    if (set_i) busy_d[set_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end
  assign busy_a_o = busy_q[rd_a_i];
  assign busy_b_o = busy_q[rd_b_i];
endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I decoder with valid/ready handshakes, flush, optional M ops and load-use stalls.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int REG_AW     = DEF_REG_AW,
  parameter bit ENABLE_M   = 1'b0,
  parameter bit SCOREBOARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [9:0]        alu_ctrl,
  output logic [XLEN-1:0]   imm,
  output logic              imm_en,
  output logic [REG_AW:0]   sel_a,
  output logic [REG_AW-1:0] sel_b,
  output logic [REG_AW-1:0] sel_out,
  output logic [2:0]        jmp_type,
  output logic              new_jmp,
  output logic [REG_AW+3:0] lam_ctrl,
  output logic              lam_new,
  output logic              demux_alu,
  output logic              illegal,
  input  logic              lam_done,
  input  logic [REG_AW-1:0] lam_done_rd
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  bundle_t dec, out_q, out_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic out_valid_q, out_valid_d, use_a, use_b, ill, hazard, accept, ld_pend;
  logic [REG_AW-1:0] ld_rd;
  assign opc = in_instr[6:0];
  assign rd  = in_instr[11:7];
  assign f3  = in_instr[14:12];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign f7  = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  always_comb begin
    dec = '0;
    use_a = 1'b0;
    use_b = 1'b0;
    ill = 1'b0;
    case (opc)
      OPC_OP: begin
        dec.sel_a = {1'b0, rs1};
        dec.sel_b = rs2;
        dec.sel_out = rd;
        dec.alu_ctrl = {f7, f3};
        use_a = 1'b1;
        use_b = 1'b1;
        ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) || (ENABLE_M && f7 == 7'h01));
      end
      OPC_OP_IMM: begin
        dec.sel_a = {1'b0, rs1};
        dec.sel_out = rd;
        dec.imm_en = 1'b1;
        dec.imm = (f3[1:0] == 2'b01) ? XLEN'(in_instr[24:20]) : imm_i;
        dec.alu_ctrl = (f3[1:0] == 2'b01) ? {f7, f3} : {7'b0, f3};
        use_a = 1'b1;
      end
      OPC_BRANCH: begin
        dec.sel_a = {1'b0, rs1};
        dec.sel_b = rs2;
        dec.imm = imm_b;
        dec.alu_ctrl = ALU_SUB;
        dec.jmp_type = f3;
        dec.new_jmp = 1'b1;
        use_a = 1'b1;
        use_b = 1'b1;
        ill = f3[2:1] == 2'b01;
      end
      OPC_JAL: begin
        dec.imm = imm_j;
        dec.sel_out = rd;
        dec.new_jmp = 1'b1;
        dec.jmp_type = JAL_BITS;
      end
      OPC_JALR: begin
        dec.sel_a = {1'b0, rs1};
        dec.imm = imm_i;
        dec.sel_out = rd;
        dec.new_jmp = 1'b1;
        dec.jmp_type = JALR_BITS;
        use_a = 1'b1;
        ill = f3 != 3'b000;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.imm = imm_u;
        dec.sel_out = rd;
        dec.imm_en = 1'b1;
        dec.sel_a = (opc == OPC_AUIPC) ? {1'b1, {REG_AW{1'b0}}} : '0;
        dec.alu_ctrl = (opc == OPC_AUIPC) ? ALU_AUIPC : ALU_LUI;
      end
      OPC_LOAD, OPC_STORE: begin
        dec.sel_a = {1'b0, rs1};
        dec.sel_b = (opc == OPC_STORE) ? rs2 : '0;
        dec.imm = (opc == OPC_STORE) ? imm_s : imm_i;
        dec.alu_ctrl = ALU_ADD;
        dec.imm_en = 1'b1;
        dec.lam_new = 1'b1;
        dec.demux_alu = 1'b1;
        dec.lam_ctrl = (opc == OPC_STORE) ? {1'b1, f3, rs2} : {1'b0, f3, rd};
        use_a = 1'b1;
        use_b = opc == OPC_STORE;
        ill = (opc == OPC_STORE) ? f3 > 3'b010 : (f3 == 3'b011 || f3[2:1] == 2'b11);
      end
      default: ill = 1'b1;
    endcase
    if (ill) dec = '0;
    dec.illegal = ill;
  end
  // a load still sitting in the out register is not in the scoreboard yet
  assign ld_rd   = out_q.lam_ctrl[REG_AW-1:0];
  assign ld_pend = out_valid_q & out_q.lam_new & !out_q.lam_ctrl[REG_AW+3] & (|ld_rd);
  generate
    if (SCOREBOARD) begin : g_sb
      logic busy_a, busy_b;
      rv_load_scoreboard #(.REG_AW(REG_AW)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_i    (ld_pend & out_ready),
        .set_rd_i (ld_rd),
        .clr_i    (lam_done),
        .clr_rd_i (lam_done_rd),
        .rd_a_i   (rs1),
        .rd_b_i   (rs2),
        .busy_a_o (busy_a),
        .busy_b_o (busy_b)
      );
      assign hazard = in_valid & ((use_a & (busy_a | (ld_pend & rs1 == ld_rd))) |
                                  (use_b & (busy_b | (ld_pend & rs2 == ld_rd))));
    end else begin : g_nosb
      assign hazard = 1'b0;
    end
  endgenerate
  assign in_ready = (!out_valid_q | out_ready) & !hazard & !flush;
  assign accept   = in_valid & in_ready;
  always_comb begin
    out_valid_d = flush ? 1'b0 : accept | (out_valid_q & !out_ready);
    out_d = accept ? dec : out_q;
    pc_d = accept ? in_pc : pc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q <= '0;
      pc_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q <= out_d;
      pc_q <= pc_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_pc    = pc_q;
  assign alu_ctrl  = out_q.alu_ctrl;
  assign imm       = out_q.imm;
  assign imm_en    = out_q.imm_en;
  assign sel_a     = out_q.sel_a;
  assign sel_b     = out_q.sel_b;
  assign sel_out   = out_q.sel_out;
  assign jmp_type  = out_q.jmp_type;
  assign new_jmp   = out_q.new_jmp;
  assign lam_ctrl  = out_q.lam_ctrl;
  assign lam_new   = out_q.lam_new;
  assign demux_alu = out_q.demux_alu;
  assign illegal   = out_q.illegal;
endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: directed decode table plus stall, backpressure, flush and reset sequences.
module tb_rv_decode_stage;
  import rv_decode_pkg::*;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1, lam_done = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic [4:0] lam_done_rd = '0;
  logic in_ready, out_valid, imm_en, new_jmp, lam_new, demux_alu, illegal;
  logic [31:0] out_pc, imm;
  logic [9:0] alu_ctrl;
  logic [5:0] sel_a;
  logic [4:0] sel_b, sel_out;
  logic [2:0] jmp_type;
  logic [8:0] lam_ctrl;
  logic m_in_ready, m_out_valid, m_imm_en, m_new_jmp, m_lam_new, m_demux_alu, m_illegal;
  logic [31:0] m_out_pc, m_imm;
  logic [9:0] m_alu_ctrl;
  logic [5:0] m_sel_a;
  logic [4:0] m_sel_b, m_sel_out;
  logic [2:0] m_jmp_type;
  logic [8:0] m_lam_ctrl;
  int pass_n = 0, total_n = 0;

  rv_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .alu_ctrl(alu_ctrl),
    .imm(imm), .imm_en(imm_en), .sel_a(sel_a), .sel_b(sel_b), .sel_out(sel_out), .jmp_type(jmp_type),
    .new_jmp(new_jmp), .lam_ctrl(lam_ctrl), .lam_new(lam_new), .demux_alu(demux_alu), .illegal(illegal),
    .lam_done(lam_done), .lam_done_rd(lam_done_rd));

  rv_decode_stage #(.ENABLE_M(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(m_out_valid), .out_ready(out_ready), .out_pc(m_out_pc), .alu_ctrl(m_alu_ctrl),
    .imm(m_imm), .imm_en(m_imm_en), .sel_a(m_sel_a), .sel_b(m_sel_b), .sel_out(m_sel_out), .jmp_type(m_jmp_type),
    .new_jmp(m_new_jmp), .lam_ctrl(m_lam_ctrl), .lam_new(m_lam_new), .demux_alu(m_demux_alu), .illegal(m_illegal),
    .lam_done(lam_done), .lam_done_rd(lam_done_rd));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    bundle_t     exp;
  } vec_t;

  function automatic bundle_t mk(input logic [9:0] alu, input logic [31:0] im, input logic ie,
                                 input logic [5:0] a, input logic [4:0] b, input logic [4:0] o,
                                 input logic [2:0] jt, input logic nj, input logic [8:0] lc,
                                 input logic ln, input logic dm, input logic il);
    bundle_t r;
    r.alu_ctrl = alu; r.imm = im; r.imm_en = ie; r.sel_a = a; r.sel_b = b; r.sel_out = o;
    r.jmp_type = jt; r.new_jmp = nj; r.lam_ctrl = lc; r.lam_new = ln; r.demux_alu = dm; r.illegal = il;
    return r;
  endfunction

  function automatic bundle_t cur();
    return mk(alu_ctrl, imm, imm_en, sel_a, sel_b, sel_out, jmp_type, new_jmp, lam_ctrl, lam_new, demux_alu, illegal);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v[$];
    bundle_t exp_beq;
    exp_beq = mk(ALU_SUB, 32'd8, 0, 6'd1, 5'd2, 5'd0, 3'b000, 1, 9'h0, 0, 0, 0);
    v.push_back('{32'hFFF00293, mk(10'h000, 32'hFFFFFFFF, 1, 6'd0, 5'd0, 5'd5, 3'd0, 0, 9'h0, 0, 0, 0)});
    v.push_back('{32'h002081B3, mk(10'h000, 32'h0, 0, 6'd1, 5'd2, 5'd3, 3'd0, 0, 9'h0, 0, 0, 0)});
    v.push_back('{32'h40208233, mk(10'h100, 32'h0, 0, 6'd1, 5'd2, 5'd4, 3'd0, 0, 9'h0, 0, 0, 0)});
    v.push_back('{32'h4034D413, mk(10'h105, 32'h3, 1, 6'd9, 5'd0, 5'd8, 3'd0, 0, 9'h0, 0, 0, 0)});
    v.push_back('{32'h00208463, exp_beq});
    v.push_back('{32'hFFDFF0EF, mk(10'h000, 32'hFFFFFFFC, 0, 6'd0, 5'd0, 5'd1, 3'b010, 1, 9'h0, 0, 0, 0)});
    v.push_back('{32'h00008067, mk(10'h000, 32'h0, 0, 6'd1, 5'd0, 5'd0, 3'b011, 1, 9'h0, 0, 0, 0)});
    v.push_back('{32'h12345537, mk(10'h3F8, 32'h12345000, 1, 6'd0, 5'd0, 5'd10, 3'd0, 0, 9'h0, 0, 0, 0)});
    v.push_back('{32'hFFFFF597, mk(10'h3F9, 32'hFFFFF000, 1, 6'h20, 5'd0, 5'd11, 3'd0, 0, 9'h0, 0, 0, 0)});
    v.push_back('{32'hFE21AE23, mk(10'h000, 32'hFFFFFFFC, 1, 6'd3, 5'd2, 5'd0, 3'd0, 0, 9'h142, 1, 1, 0)});
    v.push_back('{32'h0000007F, mk(10'h0, 32'h0, 0, 6'd0, 5'd0, 5'd0, 3'd0, 0, 9'h0, 0, 0, 1)});
    v.push_back('{32'h40209233, mk(10'h0, 32'h0, 0, 6'd0, 5'd0, 5'd0, 3'd0, 0, 9'h0, 0, 0, 1)});
    v.push_back('{32'h0000B303, mk(10'h0, 32'h0, 0, 6'd0, 5'd0, 5'd0, 3'd0, 0, 9'h0, 0, 0, 1)});
    v.push_back('{32'h0020A463, mk(10'h0, 32'h0, 0, 6'd0, 5'd0, 5'd0, 3'd0, 0, 9'h0, 0, 0, 1)});
    v.push_back('{32'h00009067, mk(10'h0, 32'h0, 0, 6'd0, 5'd0, 5'd0, 3'd0, 0, 9'h0, 0, 0, 1)});
    v.push_back('{32'hFE21BE23, mk(10'h0, 32'h0, 0, 6'd0, 5'd0, 5'd0, 3'd0, 0, 9'h0, 0, 0, 1)});
    v.push_back('{32'h02208033, mk(10'h0, 32'h0, 0, 6'd0, 5'd0, 5'd0, 3'd0, 0, 9'h0, 0, 0, 1)});
    v.push_back('{32'h0040A303, mk(10'h000, 32'h4, 1, 6'd1, 5'd0, 5'd0, 3'd0, 0, 9'h046, 1, 1, 0)});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_bundle", cur(), '0);
    chk("reset_pc", out_pc, 0);
    @(negedge clk) rst = 1'b0;

    foreach (v[i]) begin
      send(v[i].instr, 32'h1000 + 32'(i) * 4);
      chk($sformatf("vec%0d_bundle", i), cur(), v[i].exp);
      chk($sformatf("vec%0d_pc", i), out_pc, 32'h1000 + 32'(i) * 4);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      if (v[i].instr == 32'h02208033) begin
        chk("m_ext_alu", m_alu_ctrl, 10'h008);
        chk("m_ext_illegal", m_illegal, 0);
      end
    end

    // lw x6 is in the out register; add x7,x6,x2 must stall until lam_done for x6
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h002303B3; in_pc = 32'h2000;
    #1 chk("hz_outreg", in_ready, 0);
    repeat (3) begin
      @(negedge clk);
      #1 chk("hz_busy", in_ready, 0);
    end
    @(negedge clk);
    lam_done = 1'b1; lam_done_rd = 5'd6;
    #1 chk("hz_clear_cycle", in_ready, 0);
    @(negedge clk);
    lam_done = 1'b0;
    #1 chk("hz_released", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("hz_acc_valid", out_valid, 1);
    chk("hz_acc_rd", sel_out, 7);
    chk("hz_acc_rs1", sel_a, 6);

    send(32'h00208463, 32'h3000);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00293; in_pc = 32'h3004;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("bp_bundle", cur(), exp_beq);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_pc", out_pc, 32'h3000);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bp_release", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_next_rd", sel_out, 5);
    chk("bp_next_imm", imm, 32'hFFFFFFFF);

    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h12345537; in_pc = 32'h4000; flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1 chk("flush_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1 chk("flush_dropped", out_valid, 0);

    send(32'h0040A303, 32'h5000);
    send(32'hFFF00293, 32'h5004);
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h002303B3; in_pc = 32'h5008;
    #1 chk("rst_pre_busy", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_bundle", cur(), '0);
    chk("rst_mid_pc", out_pc, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_sb_clear", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("rst_post_valid", out_valid, 1);
    chk("rst_post_rs1", sel_a, 6);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
